// File: rtl/alarm_clock_pkg.sv
// Shared constants, state codes and the hour/minute payload type for the alarm clock.
package alarm_clock_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned RCNT_W = 8;

  localparam int unsigned HOUR_MAX    = 23;
  localparam int unsigned MIN_MAX     = 59;
  localparam int unsigned SEC_MAX     = 59;
  localparam int unsigned ALARM_RST_H = 7;
  localparam int unsigned ALARM_RST_M = 0;

  localparam logic [ST_W-1:0] ST_RUN       = 3'd0;
  localparam logic [ST_W-1:0] ST_SET_TIME  = 3'd1;
  localparam logic [ST_W-1:0] ST_SET_ALARM = 3'd2;
  localparam logic [ST_W-1:0] ST_RINGING   = 3'd3;
  localparam logic [ST_W-1:0] ST_SNOOZE    = 3'd4;

  typedef struct packed {
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
  } hm_t;

  // Add k minutes (k <= 59) to an HH:MM value, carrying into the hour, modulo 24 h.
  function automatic hm_t hm_add(input hm_t t, input int unsigned k);
    hm_t        r;
    logic [6:0] ms;
    r  = t;
    ms = 7'(t.m) + 7'(k);
    if (ms > 7'(MIN_MAX)) begin
      ms  = ms - 7'(MIN_MAX + 1);
      r.h = (t.h == HOUR_W'(HOUR_MAX)) ? '0 : t.h + 1'b1;
    end
    r.m = MIN_W'(ms);
    return r;
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// Button/tick inputs and display outputs of the alarm clock controller.
//  master: drives tick_1hz, btn_*, alarm_en; observes the display fields
//  slave : the controller side
interface alarm_clock_ctrl_if;
  import alarm_clock_pkg::*;

  logic              tick_1hz;
  logic              btn_mode;
  logic              btn_sel;
  logic              btn_inc;
  logic              btn_snooze;
  logic              alarm_en;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [SEC_W-1:0]  sec;
  logic              disp_alarm;
  logic              set_field;
  logic              ring;
  logic [ST_W-1:0]   state;

  modport master (
    output tick_1hz, btn_mode, btn_sel, btn_inc, btn_snooze, alarm_en,
    input  hour, min, sec, disp_alarm, set_field, ring, state
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_sel, btn_inc, btn_snooze, alarm_en,
    output hour, min, sec, disp_alarm, set_field, ring, state
  );

endinterface

// File: rtl/alarm_clock_ctrl_hms_counter.sv
// HH:MM:SS time-of-day counter.
//  clk, rst      : clock, async active-low reset (clears to 00:00:00)
//  tick_en       : advance one second, carrying into minute and hour
//  sec_clr       : force seconds to zero (wins over tick_en)
//  inc_h / inc_m : bump hour / minute independently, wrapping, no carry
//  hour/min/sec  : registered count
module hms_counter
  import alarm_clock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              sec_clr,
  input  logic              inc_h,
  input  logic              inc_m,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour <= '0;
      min  <= '0;
      sec  <= '0;
    end else if (sec_clr) begin
      sec <= '0;
    end else if (tick_en) begin
      if (sec == SEC_W'(SEC_MAX)) begin
        sec <= '0;
        if (min == MIN_W'(MIN_MAX)) begin
          min  <= '0;
          hour <= (hour == HOUR_W'(HOUR_MAX)) ? '0 : hour + 1'b1;
        end else begin
          min <= min + 1'b1;
        end
      end else begin
        sec <= sec + 1'b1;
      end
    end else begin
      if (inc_h) hour <= (hour == HOUR_W'(HOUR_MAX)) ? '0 : hour + 1'b1;
      if (inc_m) min  <= (min == MIN_W'(MIN_MAX)) ? '0 : min + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: time keeping, set-time / set-alarm mode FSM, alarm
// compare, ringing with auto-timeout, and snooze.
//  clk, rst : clock, async active-low reset
//  bus      : slave side of alarm_clock_ctrl_if (buttons, tick, alarm_en in;
//             hour/min/sec, disp_alarm, set_field, ring, state out)
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic               clk,
  input  logic               rst,
  alarm_clock_ctrl_if.slave  bus
);

  localparam int unsigned NBTN = 4;

  logic [ST_W-1:0]   st_q, st_d;
  logic              set_field_q, set_field_d;
  hm_t               al_q, al_d;
  hm_t               snz_q, snz_d;
  logic [RCNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [NBTN-1:0]   btn_q, btn_now, btn_pulse;
  logic              p_mode, p_snooze, p_sel, p_inc;
  logic              inc_h, inc_m, sec_clr, tick_en;
  logic [HOUR_W-1:0] t_hour;
  logic [MIN_W-1:0]  t_min;
  logic [SEC_W-1:0]  t_sec;
  hm_t               now_hm, next_hm;
  logic              sec_roll;

  // One-cycle press pulses from level buttons
  assign btn_now   = {bus.btn_mode, bus.btn_snooze, bus.btn_sel, bus.btn_inc};
  assign btn_pulse = btn_now & ~btn_q;
  assign p_mode    = btn_pulse[3];
  assign p_snooze  = btn_pulse[2];
  assign p_sel     = btn_pulse[1];
  assign p_inc     = btn_pulse[0];

  // Time of day freezes while it is being edited
  assign tick_en = bus.tick_1hz && (st_q != ST_SET_TIME);

  hms_counter u_time (
    .clk     (clk),
    .rst     (rst),
    .tick_en (tick_en),
    .sec_clr (sec_clr),
    .inc_h   (inc_h),
    .inc_m   (inc_m),
    .hour    (t_hour),
    .min     (t_min),
    .sec     (t_sec)
  );

  // Matches fire only on the tick that rolls seconds into a new minute
  assign now_hm   = {t_hour, t_min};
  assign next_hm  = hm_add(now_hm, 1);
  assign sec_roll = bus.tick_1hz && (t_sec == SEC_W'(SEC_MAX));

  // State and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= ST_RUN;
      set_field_q <= 1'b1;
      al_q        <= '{h: HOUR_W'(ALARM_RST_H), m: MIN_W'(ALARM_RST_M)};
      snz_q       <= '0;
      ring_cnt_q  <= '0;
      btn_q       <= '0;
    end else begin
      st_q        <= st_d;
      set_field_q <= set_field_d;
      al_q        <= al_d;
      snz_q       <= snz_d;
      ring_cnt_q  <= ring_cnt_d;
      btn_q       <= btn_now;
    end
  end

  // Next state and register updates; priority mode > snooze > sel > inc
  always_comb begin
    st_d        = st_q;
    set_field_d = set_field_q;
    al_d        = al_q;
    snz_d       = snz_q;
    ring_cnt_d  = ring_cnt_q;
    inc_h       = 1'b0;
    inc_m       = 1'b0;
    sec_clr     = 1'b0;
    case (st_q)
      ST_RUN: begin
        if (p_mode) begin
          st_d        = ST_SET_TIME;
          sec_clr     = 1'b1;
          set_field_d = 1'b1;
        end else if (bus.alarm_en && sec_roll && (next_hm == al_q)) begin
          st_d       = ST_RINGING;
          ring_cnt_d = '0;
        end
      end
      ST_SET_TIME: begin
        if (p_mode) begin
          st_d        = ST_SET_ALARM;
          set_field_d = 1'b1;
        end else if (p_sel) begin
          set_field_d = ~set_field_q;
        end else if (p_inc) begin
          inc_h = set_field_q;
          inc_m = ~set_field_q;
        end
      end
      ST_SET_ALARM: begin
        if (p_mode) begin
          st_d = ST_RUN;
        end else if (p_sel) begin
          set_field_d = ~set_field_q;
        end else if (p_inc) begin
          if (set_field_q) al_d.h = (al_q.h == HOUR_W'(HOUR_MAX)) ? '0 : al_q.h + 1'b1;
          else             al_d.m = (al_q.m == MIN_W'(MIN_MAX)) ? '0 : al_q.m + 1'b1;
        end
      end
      ST_RINGING: begin
        if (p_mode || !bus.alarm_en || (ring_cnt_q == RCNT_W'(RING_SEC))) begin
          st_d = ST_RUN;
        end else if (p_snooze) begin
          st_d  = ST_SNOOZE;
          snz_d = hm_add(now_hm, SNOOZE_MIN);
        end else if (bus.tick_1hz) begin
          ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (p_mode || !bus.alarm_en) begin
          st_d  = ST_RUN;
          snz_d = '0;
        end else if (sec_roll && (next_hm == snz_q)) begin
          st_d       = ST_RINGING;
          ring_cnt_d = '0;
        end
      end
      default: st_d = ST_RUN;
    endcase
  end

  // Display shows the alarm setting while it is being edited
  assign bus.hour       = (st_q == ST_SET_ALARM) ? al_q.h : t_hour;
  assign bus.min        = (st_q == ST_SET_ALARM) ? al_q.m : t_min;
  assign bus.sec        = t_sec;
  assign bus.disp_alarm = (st_q == ST_SET_ALARM);
  assign bus.set_field  = set_field_q;
  assign bus.ring       = (st_q == ST_RINGING);
  assign bus.state      = st_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
module tb_alarm_clock_ctrl;
  import alarm_clock_pkg::*;

  localparam int OP_TICK = 0;
  localparam int OP_MODE = 1;
  localparam int OP_SEL  = 2;
  localparam int OP_INC  = 3;
  localparam int OP_SNZ  = 4;

  typedef struct {
    int    op;
    int    n;
    int    en;
    int    eh;
    int    em;
    int    es;
    int    est;
    int    ering;
    int    esf;
    string name;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  alarm_clock_ctrl_if bus();

  alarm_clock_ctrl #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_time(input string nm, input int h, input int m, input int s);
    chk({nm, ".hour"}, int'(bus.hour), h);
    chk({nm, ".min"},  int'(bus.min),  m);
    chk({nm, ".sec"},  int'(bus.sec),  s);
  endtask

  task automatic chk_st(input string nm, input int st, input int rg);
    chk({nm, ".state"}, int'(bus.state), st);
    chk({nm, ".ring"},  int'(bus.ring),  rg);
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      bus.tick_1hz = 1'b1;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input int op);
    case (op)
      OP_MODE: bus.btn_mode   = 1'b1;
      OP_SEL:  bus.btn_sel    = 1'b1;
      OP_INC:  bus.btn_inc    = 1'b1;
      default: bus.btn_snooze = 1'b1;
    endcase
    @(negedge clk);
    bus.btn_mode   = 1'b0;
    bus.btn_sel    = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_snooze = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_op(input int op, input int n);
    if (op == OP_TICK) do_tick(n);
    else repeat (n) press(op);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.tick_1hz   = 1'b0;
    bus.btn_mode   = 1'b0;
    bus.btn_sel    = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_snooze = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Reset, then set time th:tm (sec 0) and alarm ah:am through the buttons; ends in RUN.
  task automatic set_all(input int th, input int tm, input int ah, input int am);
    do_reset();
    press(OP_MODE);
    do_op(OP_INC, th);
    press(OP_SEL);
    do_op(OP_INC, tm);
    press(OP_MODE);
    do_op(OP_INC, (ah + 17) % 24);
    press(OP_SEL);
    do_op(OP_INC, am);
    press(OP_MODE);
  endtask

  task automatic start_ring_0700();
    set_all(6, 59, 7, 0);
    bus.alarm_en = 1'b1;
    do_tick(60);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.tick_1hz   = 1'b0;
    bus.btn_mode   = 1'b0;
    bus.btn_sel    = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_snooze = 1'b0;
    bus.alarm_en   = 1'b0;

    // Table: mode/set editing walk
    vecs.push_back('{OP_MODE, 1,  0, 0, 0, 0, 1, 0, 1, "v_enter_set_time"});
    vecs.push_back('{OP_INC,  3,  0, 3, 0, 0, 1, 0, 1, "v_inc_hour3"});
    vecs.push_back('{OP_TICK, 5,  0, 3, 0, 0, 1, 0, 1, "v_tick_ignored"});
    vecs.push_back('{OP_SEL,  1,  0, 3, 0, 0, 1, 0, 0, "v_sel_minute"});
    vecs.push_back('{OP_INC,  61, 0, 3, 1, 0, 1, 0, 0, "v_inc_min61"});
    vecs.push_back('{OP_MODE, 1,  0, 7, 0, 0, 2, 0, 1, "v_enter_set_alarm"});
    vecs.push_back('{OP_SEL,  1,  0, 7, 0, 0, 2, 0, 0, "v_alarm_sel"});
    vecs.push_back('{OP_INC,  2,  0, 7, 2, 0, 2, 0, 0, "v_alarm_min2"});
    vecs.push_back('{OP_TICK, 3,  0, 7, 2, 3, 2, 0, 0, "v_tick_in_set_alarm"});
    vecs.push_back('{OP_MODE, 1,  0, 3, 1, 3, 0, 0, 0, "v_back_to_run"});
    vecs.push_back('{OP_TICK, 57, 0, 3, 2, 0, 0, 0, 0, "v_run_carry"});

    do_reset();
    chk_time("reset", 0, 0, 0);
    chk_st("reset", 0, 0);
    chk("reset.set_field", int'(bus.set_field), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.alarm_en = vecs[i].en[0];
      do_op(vecs[i].op, vecs[i].n);
      chk_time(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es);
      chk_st(vecs[i].name, vecs[i].est, vecs[i].ering);
      chk({vecs[i].name, ".disp_alarm"}, int'(bus.disp_alarm), (vecs[i].est == 2) ? 1 : 0);
      if (vecs[i].est == 1 || vecs[i].est == 2)
        chk({vecs[i].name, ".set_field"}, int'(bus.set_field), vecs[i].esf);
    end

    // Reset mid-count
    bus.alarm_en = 1'b0;
    set_all(12, 34, 7, 0);
    do_tick(56);
    chk_time("pre_reset", 12, 34, 56);
    rst = 1'b0;
    #1;
    chk_time("async_reset", 0, 0, 0);
    chk_st("async_reset", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(OP_MODE);
    press(OP_MODE);
    chk_time("alarm_after_reset", 7, 0, 0);
    press(OP_MODE);

    // Full-day rollover
    set_all(23, 59, 7, 0);
    do_tick(59);
    chk_time("roll_2359_59", 23, 59, 59);
    do_tick(1);
    chk_time("roll_midnight", 0, 0, 0);

    // Edit landing on alarm time does not trigger
    bus.alarm_en = 1'b1;
    do_reset();
    press(OP_MODE);
    do_op(OP_INC, 7);
    chk_st("edit_on_alarm", 1, 0);
    press(OP_MODE);
    press(OP_MODE);
    chk_st("edit_exit_run", 0, 0);

    // Alarm trigger, ring latency and auto-timeout
    set_all(6, 59, 7, 0);
    bus.alarm_en = 1'b1;
    do_tick(59);
    chk_time("alarm_pre", 6, 59, 59);
    bus.tick_1hz = 1'b1;
    #1;
    chk_st("alarm_same_cycle", 0, 0);
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    chk_st("alarm_next_cycle", 3, 1);
    @(negedge clk);
    do_tick(59);
    chk_st("ring_59", 3, 1);
    do_tick(1);
    chk_st("ring_timeout", 0, 0);
    chk_time("ring_timeout", 7, 1, 0);

    // Mode dismiss; no retrigger in the same minute
    start_ring_0700();
    do_tick(5);
    press(OP_MODE);
    chk_st("dismiss", 0, 0);
    do_tick(55);
    chk_st("no_retrigger", 0, 0);

    // alarm_en dropped while ringing
    start_ring_0700();
    bus.alarm_en = 1'b0;
    @(negedge clk);
    chk_st("ring_en_drop", 0, 0);

    // Reset mid-ring
    start_ring_0700();
    chk_st("ring_before_rst", 3, 1);
    rst = 1'b0;
    #1;
    chk_st("ring_async_reset", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Alarm disabled never rings
    bus.alarm_en = 1'b0;
    set_all(6, 59, 7, 0);
    do_tick(60);
    chk_st("disabled_0700", 0, 0);
    do_tick(5);
    chk_st("disabled_later", 0, 0);

    // Snooze at 07:00:10 -> ring again at 07:05:00
    start_ring_0700();
    do_tick(10);
    chk_time("snz_at", 7, 0, 10);
    press(OP_SNZ);
    chk_st("snz_enter", 4, 0);
    do_tick(289);
    chk_time("snz_pre", 7, 4, 59);
    chk_st("snz_pre", 4, 0);
    do_tick(1);
    chk_st("snz_ring", 3, 1);
    press(OP_MODE);
    chk_st("snz_dismiss", 0, 0);

    // mode and snooze together while ringing: mode wins
    start_ring_0700();
    bus.btn_mode   = 1'b1;
    bus.btn_snooze = 1'b1;
    @(negedge clk);
    bus.btn_mode   = 1'b0;
    bus.btn_snooze = 1'b0;
    @(negedge clk);
    chk_st("mode_snz_same", 0, 0);
    do_tick(300);
    chk_st("mode_snz_no_target", 0, 0);

    // alarm_en drop in SNOOZE discards the target
    start_ring_0700();
    press(OP_SNZ);
    bus.alarm_en = 1'b0;
    @(negedge clk);
    chk_st("snz_en_drop", 0, 0);
    bus.alarm_en = 1'b1;
    do_tick(300);
    chk_time("snz_en_drop_0705", 7, 5, 0);
    chk_st("snz_en_drop_0705", 0, 0);

    // Snooze across midnight: 23:58 + 5 -> 00:03
    set_all(23, 57, 23, 58);
    bus.alarm_en = 1'b1;
    do_tick(60);
    chk_st("late_ring", 3, 1);
    press(OP_SNZ);
    do_tick(299);
    chk_time("late_pre", 0, 2, 59);
    chk_st("late_pre", 4, 0);
    do_tick(1);
    chk_time("late_ring_0003", 0, 3, 0);
    chk_st("late_ring_0003", 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
